// File: rtl/operand_fetch_if.sv
// Handshake and register-file bundle between operand_fetch and its neighbours:
// the upstream instruction source, the register file read port and the execute stage.
interface operand_fetch_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [BUS_WIDTH-1:0]  instr;
    logic [BUS_WIDTH-1:0]  pc;
    logic                  flush;

    logic [ADDR_WIDTH-1:0] rs_addr;
    logic                  rs_addr_sel;
    logic                  rs_addr_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [BUS_WIDTH-1:0]  rs_data;
    logic                  rs_data_sel;
    logic                  rs_data_valid;

    logic                  op_valid;
    logic                  op_ready;
    logic [BUS_WIDTH-1:0]  op_rs1_data;
    logic [BUS_WIDTH-1:0]  op_rs2_data;
    logic [ADDR_WIDTH-1:0] op_rd_addr;
    logic [BUS_WIDTH-1:0]  op_pc;
    logic [BUS_WIDTH-1:0]  op_instr;

    // The operand fetch stage itself.
    modport master (
        input  instr_valid, instr, pc, flush,
        input  rs_data, rs_data_sel, rs_data_valid, op_ready,
        output instr_ready, rs_addr, rs_addr_sel, rs_addr_valid, rd_addr,
        output op_valid, op_rs1_data, op_rs2_data, op_rd_addr, op_pc, op_instr
    );

    // The surrounding pipeline: instruction source, register file and execute stage.
    modport slave (
        output instr_valid, instr, pc, flush,
        output rs_data, rs_data_sel, rs_data_valid, op_ready,
        input  instr_ready, rs_addr, rs_addr_sel, rs_addr_valid, rd_addr,
        input  op_valid, op_rs1_data, op_rs2_data, op_rd_addr, op_pc, op_instr
    );
endinterface

// File: rtl/operand_fetch.sv
// RV32I decode/operand-fetch stage: reads up to two source registers through a
// single shared register-file read port and hands a complete bundle to execute.
module operand_fetch #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.master   bus
);
    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, OUT} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic                  need2_q;

    logic [6:0]            opcode;
    logic [ADDR_WIDTH-1:0] rs1_i, rs2_i, rd_i;
    logic                  use_rs1, use_rs2, rd_used, need1, need2, accept;

    // Decode is done on the incoming word; only what later states need is kept.
    assign opcode  = bus.instr[6:0];
    assign rs1_i   = ADDR_WIDTH'(bus.instr[19:15]);
    assign rs2_i   = ADDR_WIDTH'(bus.instr[24:20]);
    assign rd_i    = ADDR_WIDTH'(bus.instr[11:7]);
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign use_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign rd_used = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH));
    assign need1   = use_rs1 && (rs1_i != '0);
    assign need2   = use_rs2 && (rs2_i != '0);
    assign accept  = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        // NOTE: every register here, including the wide operand/bundle registers,
        // has an explicit reset so the outputs are fully defined after rst.
        if (rst) begin
            state             <= IDLE;
            rs2_q             <= '0;
            need2_q           <= 1'b0;
            bus.instr_ready   <= 1'b0;
            bus.rs_addr       <= '0;
            bus.rs_addr_sel   <= 1'b0;
            bus.rs_addr_valid <= 1'b0;
            bus.rd_addr       <= '0;
            bus.op_valid      <= 1'b0;
            bus.op_rs1_data   <= '0;
            bus.op_rs2_data   <= '0;
            bus.op_rd_addr    <= '0;
            bus.op_pc         <= '0;
            bus.op_instr      <= '0;
        end else if (bus.flush) begin
            // Kill wins over accept and response capture; nothing is requested.
            state             <= IDLE;
            bus.instr_ready   <= 1'b1;
            bus.rs_addr_valid <= 1'b0;
            bus.op_valid      <= 1'b0;
            bus.rd_addr       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // register values from before this edge regardless of statement order.
            case (state)
                IDLE: begin
                    bus.instr_ready <= 1'b1;
                    if (accept) begin
                        bus.instr_ready <= 1'b0;
                        bus.op_pc       <= bus.pc;
                        bus.op_instr    <= bus.instr;
                        bus.op_rs1_data <= '0;
                        bus.op_rs2_data <= '0;
                        bus.rd_addr     <= rd_used ? rd_i : '0;
                        bus.op_rd_addr  <= rd_used ? rd_i : '0;
                        rs2_q           <= rs2_i;
                        need2_q         <= need2;
                        if (need1) begin
                            state             <= REQ1;
                            bus.rs_addr_valid <= 1'b1;
                            bus.rs_addr       <= rs1_i;
                            bus.rs_addr_sel   <= 1'b0;
                        end else if (need2) begin
                            state             <= REQ2;
                            bus.rs_addr_valid <= 1'b1;
                            bus.rs_addr       <= rs2_i;
                            bus.rs_addr_sel   <= 1'b1;
                        end else begin
                            state        <= OUT;
                            bus.op_valid <= 1'b1;
                        end
                    end
                end
                REQ1: begin
                    bus.rs_addr_valid <= 1'b0;
                    state             <= WAIT1;
                end
                WAIT1: begin
                    // A response tagged for rs2 cannot belong to this request.
                    if (bus.rs_data_valid && !bus.rs_data_sel) begin
                        bus.op_rs1_data <= bus.rs_data;
                        if (need2_q) begin
                            state             <= REQ2;
                            bus.rs_addr_valid <= 1'b1;
                            bus.rs_addr       <= rs2_q;
                            bus.rs_addr_sel   <= 1'b1;
                        end else begin
                            state        <= OUT;
                            bus.op_valid <= 1'b1;
                        end
                    end
                end
                REQ2: begin
                    bus.rs_addr_valid <= 1'b0;
                    state             <= WAIT2;
                end
                WAIT2: begin
                    if (bus.rs_data_valid && bus.rs_data_sel) begin
                        bus.op_rs2_data <= bus.rs_data;
                        state           <= OUT;
                        bus.op_valid    <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.op_ready) begin
                        state           <= IDLE;
                        bus.op_valid    <= 1'b0;
                        bus.instr_ready <= 1'b1;
                        bus.rd_addr     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: each task drives one scenario cycle by cycle
// and compares outputs one time unit after the rising edge.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    operand_fetch_if #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    operand_fetch #(.BUS_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_valid   = 1'b0;
        bus.instr         = '0;
        bus.pc            = '0;
        bus.flush         = 1'b0;
        bus.rs_data       = '0;
        bus.rs_data_sel   = 1'b0;
        bus.rs_data_valid = 1'b0;
        bus.op_ready      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        total++; if (bus.instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.instr_ready); end
        total++; if ({bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr, bus.rd_addr} !== 12'h000) begin bad++;
            $display("FAIL reset_req: got %h want 000", {bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr, bus.rd_addr}); end
        total++; if ({bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.op_pc, bus.op_instr} !== '0) begin bad++;
            $display("FAIL reset_bundle: got %h want 0", {bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.op_pc, bus.op_instr}); end
        rst = 1'b0;
        step();
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", bus.instr_ready); end
    endtask

    // Instruction reading rs1 then rs2, register file answering one cycle after each request.
    task automatic test_two_reads(input string name, input logic [31:0] ins, input logic [31:0] pcv,
                                  input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] exp_rd);
        logic [4:0] e_rs1, e_rs2;
        e_rs1 = ins[19:15];
        e_rs2 = ins[24:20];
        // cycle 0: accept
        bus.instr_valid = 1'b1; bus.instr = ins; bus.pc = pcv;
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL %s accept_ready: got %b want 1", name, bus.instr_ready); end
        step();
        // cycle 1: rs1 request
        bus.instr_valid = 1'b0; bus.instr = 32'hFFFF_FFFF; bus.pc = 32'hFFFF_FFFF;
        total++; if ({bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr} !== {2'b10, e_rs1}) begin bad++;
            $display("FAIL %s req1: got %b want %b", name, {bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr}, {2'b10, e_rs1}); end
        total++; if (bus.rd_addr !== exp_rd) begin bad++; $display("FAIL %s rd_c1: got %0d want %0d", name, bus.rd_addr, exp_rd); end
        step();
        // cycle 2: rs1 data
        bus.rs_data_valid = 1'b1; bus.rs_data_sel = 1'b0; bus.rs_data = d1;
        total++; if (bus.rs_addr_valid !== 1'b0) begin bad++; $display("FAIL %s req1_one_cycle: got %b want 0", name, bus.rs_addr_valid); end
        step();
        // cycle 3: rs2 request
        bus.rs_data_valid = 1'b0; bus.rs_data = '0;
        total++; if ({bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr} !== {2'b11, e_rs2}) begin bad++;
            $display("FAIL %s req2: got %b want %b", name, {bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr}, {2'b11, e_rs2}); end
        total++; if (bus.rd_addr !== exp_rd) begin bad++; $display("FAIL %s rd_c3: got %0d want %0d", name, bus.rd_addr, exp_rd); end
        step();
        // cycle 4: rs2 data
        bus.rs_data_valid = 1'b1; bus.rs_data_sel = 1'b1; bus.rs_data = d2;
        total++; if ({bus.rs_addr_valid, bus.op_valid} !== 2'b00) begin bad++;
            $display("FAIL %s wait2: got %b want 00", name, {bus.rs_addr_valid, bus.op_valid}); end
        step();
        // cycle 5: bundle out
        bus.rs_data_valid = 1'b0; bus.rs_data_sel = 1'b0; bus.rs_data = '0; bus.op_ready = 1'b1;
        total++; if ({bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.op_pc, bus.op_instr} !== {1'b1, d1, d2, exp_rd, pcv, ins}) begin bad++;
            $display("FAIL %s bundle: got %h want %h", name, {bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.op_pc, bus.op_instr}, {1'b1, d1, d2, exp_rd, pcv, ins}); end
        total++; if (bus.rd_addr !== exp_rd) begin bad++; $display("FAIL %s rd_c5: got %0d want %0d", name, bus.rd_addr, exp_rd); end
        step();
        bus.op_ready = 1'b0;
        total++; if ({bus.op_valid, bus.instr_ready, bus.rd_addr} !== 7'b01_00000) begin bad++;
            $display("FAIL %s after_handshake: got %b want 0100000", name, {bus.op_valid, bus.instr_ready, bus.rd_addr}); end
    endtask

    task automatic test_no_read(input string name, input logic [31:0] ins, input logic [31:0] pcv, input logic [4:0] exp_rd);
        bus.instr_valid = 1'b1; bus.instr = ins; bus.pc = pcv;
        step();
        bus.instr_valid = 1'b0; bus.op_ready = 1'b1;
        total++; if (bus.rs_addr_valid !== 1'b0) begin bad++; $display("FAIL %s no_request: got %b want 0", name, bus.rs_addr_valid); end
        total++; if ({bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.op_pc, bus.op_instr} !== {1'b1, 64'h0, exp_rd, pcv, ins}) begin bad++;
            $display("FAIL %s bundle: got %h want %h", name, {bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.op_pc, bus.op_instr}, {1'b1, 64'h0, exp_rd, pcv, ins}); end
        total++; if (bus.rd_addr !== exp_rd) begin bad++; $display("FAIL %s rd_addr: got %0d want %0d", name, bus.rd_addr, exp_rd); end
        step();
        bus.op_ready = 1'b0;
        total++; if ({bus.op_valid, bus.instr_ready} !== 2'b01) begin bad++; $display("FAIL %s after_handshake: got %b want 01", name, {bus.op_valid, bus.instr_ready}); end
    endtask

    // Wrong-sel response in WAIT1 is ignored; then execute stage stalls three cycles.
    task automatic test_spurious_backpressure();
        bus.instr_valid = 1'b1; bus.instr = 32'h002081B3; bus.pc = 32'h0000_0200;
        step();
        bus.instr_valid = 1'b0;
        step();
        // WAIT1: inject an rs2-tagged response
        bus.rs_data_valid = 1'b1; bus.rs_data_sel = 1'b1; bus.rs_data = 32'hDEAD_BEEF;
        step();
        total++; if (bus.rs_addr_valid !== 1'b0) begin bad++; $display("FAIL spurious_ignored: got rs_addr_valid %b want 0", bus.rs_addr_valid); end
        bus.rs_data_sel = 1'b0; bus.rs_data = 32'h0000_0033;
        step();
        bus.rs_data_valid = 1'b0; bus.rs_data = '0;
        total++; if ({bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr} !== 7'b11_00010) begin bad++;
            $display("FAIL spurious_req2: got %b want 1100010", {bus.rs_addr_valid, bus.rs_addr_sel, bus.rs_addr}); end
        step();
        bus.rs_data_valid = 1'b1; bus.rs_data_sel = 1'b1; bus.rs_data = 32'h0000_0044;
        step();
        bus.rs_data_valid = 1'b0; bus.rs_data_sel = 1'b0; bus.rs_data = '0;
        for (int i = 0; i < 4; i++) begin
            bus.op_ready = (i == 3);
            total++; if ({bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.instr_ready} !== {1'b1, 32'h33, 32'h44, 5'd3, 1'b0}) begin bad++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, {bus.op_valid, bus.op_rs1_data, bus.op_rs2_data, bus.op_rd_addr, bus.instr_ready}, {1'b1, 32'h33, 32'h44, 5'd3, 1'b0}); end
            step();
        end
        bus.op_ready = 1'b0;
        total++; if ({bus.op_valid, bus.instr_ready} !== 2'b01) begin bad++; $display("FAIL stall_release: got %b want 01", {bus.op_valid, bus.instr_ready}); end
    endtask

    task automatic test_flush();
        bus.instr_valid = 1'b1; bus.instr = 32'h002081B3; bus.pc = 32'h0000_0300;
        step();
        bus.instr_valid = 1'b0;
        step();
        bus.rs_data_valid = 1'b1; bus.rs_data_sel = 1'b0; bus.rs_data = 32'h11;
        step();
        bus.rs_data_valid = 1'b0;
        step();
        // WAIT2: kill before the rs2 answer arrives
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.rs_data_valid = 1'b1; bus.rs_data_sel = 1'b1; bus.rs_data = 32'h99;
        total++; if ({bus.instr_ready, bus.op_valid, bus.rs_addr_valid, bus.rd_addr} !== 8'b100_00000) begin bad++;
            $display("FAIL flush_idle: got %b want 10000000", {bus.instr_ready, bus.op_valid, bus.rs_addr_valid, bus.rd_addr}); end
        step();
        bus.rs_data_valid = 1'b0; bus.rs_data_sel = 1'b0; bus.rs_data = '0;
        total++; if ({bus.instr_ready, bus.op_valid} !== 2'b10) begin bad++; $display("FAIL flush_late_data: got %b want 10", {bus.instr_ready, bus.op_valid}); end
        // flush in IDLE blocks an offered instruction
        bus.instr_valid = 1'b1; bus.instr = 32'h00700293; bus.flush = 1'b1;
        step();
        bus.instr_valid = 1'b0; bus.flush = 1'b0;
        total++; if ({bus.instr_ready, bus.op_valid, bus.rd_addr} !== 7'b10_00000) begin bad++;
            $display("FAIL flush_blocks_accept: got %b want 1000000", {bus.instr_ready, bus.op_valid, bus.rd_addr}); end
        test_two_reads("after_flush", 32'h002081B3, 32'h0000_0304, 32'h0BAD_F00D, 32'h1234_5678, 5'd3);
    endtask

    task automatic test_reset_in_out();
        bus.instr_valid = 1'b1; bus.instr = 32'h123453B7; bus.pc = 32'h0000_0400;
        step();
        bus.instr_valid = 1'b0;
        total++; if (bus.op_valid !== 1'b1) begin bad++; $display("FAIL rst_out_reached: got %b want 1", bus.op_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({bus.instr_ready, bus.op_valid, bus.rs_addr_valid, bus.rd_addr, bus.op_rd_addr, bus.op_pc, bus.op_instr} !== '0) begin bad++;
            $display("FAIL rst_in_out: got %h want 0", {bus.instr_ready, bus.op_valid, bus.rs_addr_valid, bus.rd_addr, bus.op_rd_addr, bus.op_pc, bus.op_instr}); end
        step();
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", bus.instr_ready); end
    endtask

    initial begin
        test_reset();
        test_two_reads("add", 32'h002081B3, 32'h0000_0100, 32'h0000_0011, 32'h0000_0022, 5'd3);
        test_no_read("addi", 32'h00700293, 32'h0000_0104, 5'd5);
        test_no_read("lui", 32'h123453B7, 32'h0000_0108, 5'd7);
        test_two_reads("sw", 32'h0020A023, 32'h0000_010C, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd0);
        test_spurious_backpressure();
        test_flush();
        test_reset_in_out();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage directly upstream of the register file. Accepts one RV32I instruction at a time over a valid/ready handshake, extracts rs1/rs2/rd, reads the needed source operands through the register file's single shared read port (`rs_addr_sel` selects rs1/rs2), and presents a complete operand bundle to the execute stage over a second valid/ready handshake. Unneeded reads and reads of x0 are skipped.

## Interface
- `BUS_WIDTH`, 32, data width of operands, `pc` and instruction
- `ADDR_WIDTH`, 5, register index width
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  upstream instruction valid
- `instr_ready`  out  1  stage can accept an instruction
- `instr`  in  BUS_WIDTH  instruction word
- `pc`  in  BUS_WIDTH  instruction address
- `flush`  in  1  synchronous kill of the in-flight instruction
- `rs_addr`  out  ADDR_WIDTH  register index for current read request
- `rs_addr_sel`  out  1  0 = rs1 request, 1 = rs2 request
- `rs_addr_valid`  out  1  one-cycle read request strobe
- `rd_addr`  out  ADDR_WIDTH  destination index of in-flight instruction
- `rs_data`  in  BUS_WIDTH  read data from register file
- `rs_data_sel`  in  1  which request `rs_data` answers
- `rs_data_valid`  in  1  read data valid
- `op_valid`  out  1  operand bundle valid
- `op_ready`  in  1  execute stage accepts bundle
- `op_rs1_data`, `op_rs2_data`  out  BUS_WIDTH  source operands
- `op_rd_addr`  out  ADDR_WIDTH  destination index
- `op_pc`, `op_instr`  out  BUS_WIDTH  captured pc and instruction

## Operation
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, OUT. `instr_ready` = 1 only in IDLE (and not in reset).
- Accept on `instr_valid && instr_ready`: capture `instr`, `pc`; rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]; operand registers cleared to 0.
- Operand usage by opcode instr[6:0]: 0110011/0100011/1100011 use rs1+rs2; 0110111/0010111/1101111 use neither; all others use rs1 only.
- rd_used = 0 for 0100011 and 1100011; unused rd drives 0 on `rd_addr`/`op_rd_addr`.
- need1 = rs1 used and rs1 != 0; need2 = rs2 used and rs2 != 0. Skipped operand stays 0.
- IDLE→REQ1 if need1, else REQ2 if need2, else OUT.
- REQ1: `rs_addr_valid`=1, `rs_addr`=rs1, `rs_addr_sel`=0 for exactly one cycle → WAIT1.
- WAIT1: on `rs_data_valid && rs_data_sel==0` capture rs1 operand → REQ2 if need2 else OUT. Responses with wrong sel are ignored.
- REQ2/WAIT2: same with rs2, sel=1 → OUT.
- OUT: `op_valid`=1, bundle stable until `op_valid && op_ready`, then → IDLE.
- `rs_data_valid` in IDLE, REQ*, OUT is ignored (stale responses after flush discarded).
- `flush` (any state): next state IDLE, `op_valid` 0, no request that cycle; flush has priority over accept and over response capture. `flush` in IDLE with `instr_valid` high: instruction not accepted.
- `rst` overrides everything, including `flush`.

## Timing
- Reset values: state IDLE, `instr_ready` 0 while `rst` high then 1, `rs_addr_valid` 0, `rs_addr` 0, `rs_addr_sel` 0, `rd_addr` 0, `op_valid` 0, all `op_*` 0.
- `rs_addr`, `rs_addr_sel`, `rs_addr_valid`, `op_*`, `instr_ready` are registered outputs; `rd_addr` held from accept until leaving OUT, 0 in IDLE.
- Accept at cycle 0; no-read instruction: `op_valid` cycle 1.
- Two reads, register file answering one cycle after request: rs1 request cycle 1, data cycle 2, rs2 request cycle 3, data cycle 4, `op_valid` cycle 5.
- Read response valid no earlier than the cycle after request; unbounded wait permitted.
- Throughput: at most one instruction in flight; next accept earliest the cycle after OUT handshake.

## Test plan
- `add x3,x1,x2` (0x002081B3), regfile returns 0x11 (sel 0) then 0x22 (sel 1) one cycle after each request → requests rs_addr 1/sel 0 at cycle 1, 2/sel 1 at cycle 3; `op_valid` cycle 5 with rs1 0x11, rs2 0x22, rd 3, `rd_addr` 3 during cycles 1–5.
- `addi x5,x0,7` (0x00700293) and `lui x7,0x12345` (0x123453B7) → no `rs_addr_valid`; `op_valid` cycle 1, operands 0, rd 5 / 7.
- `sw x2,0(x1)` (0x0020A023), data 0xA5A5A5A5/0x5A5A5A5A → both reads issued, `op_rd_addr` 0.
- `add x3,x1,x2` with a sel=1 response injected in WAIT1 and `op_ready` low 3 cycles in OUT → spurious response ignored, bundle holds stable, handshake completes on cycle `op_ready` rises, `instr_ready` returns next cycle.
- `flush` in WAIT2, then late `rs_data_valid` sel 1 → IDLE next cycle, `op_valid` never asserted, late data ignored, next instruction fetched correctly.
- `rst` asserted in OUT → next cycle all outputs at reset values; `instr_ready` 1 first cycle after `rst` drops.
